// File: rtl/time_counter.sv
// -----------------------------------------------------------------------------
// time_counter
//
// BCD time-of-day counter feeding the hourly chime and the seven-segment
// driver. Counts seconds, minutes and hours on a one-cycle 1 Hz enable and
// offers a two-key set mode (mode_key / inc_key) for hours and minutes.
// Every output comes straight from a register, so it only moves on a
// div_clk rising edge.
//
// Optional feature macro: TWELVE_HOUR_EN
//   undefined : 24 h counting, pm held at 0.
//   defined   : 12 h counting (12, 01 .. 11), pm toggles at 11 -> 12.
//
// Ports
//   div_clk    in   1  block clock
//   rst_n      in   1  synchronous active-low reset
//   sec_en     in   1  one-cycle count enable (nominally 1 Hz)
//   mode_key   in   1  one-cycle pulse: RUN -> SET_HOUR -> SET_MIN -> RUN
//   inc_key    in   1  one-cycle pulse: increment the field being set
//   secL..hourH out 4  BCD time digits
//   mode       out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN
//   hour_tick  out  1  one-cycle pulse after a RUN count reaches xx:00:00
//   pm         out  1  afternoon flag (12 h build only, else 0)
// -----------------------------------------------------------------------------
module time_counter #(
    parameter logic [3:0] RST_HOURH = 4'd0,
    parameter logic [3:0] RST_HOURL = 4'd0,
    parameter logic [3:0] RST_MINH  = 4'd0,
    parameter logic [3:0] RST_MINL  = 4'd0
) (
    input  logic       div_clk,
    input  logic       rst_n,
    input  logic       sec_en,
    input  logic       mode_key,
    input  logic       inc_key,
    output logic [3:0] secL,
    output logic [3:0] secH,
    output logic [3:0] minL,
    output logic [3:0] minH,
    output logic [3:0] hourL,
    output logic [3:0] hourH,
    output logic [1:0] mode,
    output logic       hour_tick,
    output logic       pm
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_BAD      = 2'b11
    } state_t;

`ifdef TWELVE_HOUR_EN
    localparam logic [7:0] RST_HOUR = 8'h12;
`else
    localparam logic [7:0] RST_HOUR = {RST_HOURH, RST_HOURL};
`endif
    localparam logic [7:0] RST_MIN = {RST_MINH, RST_MINL};

    // Two-digit BCD fields, tens digit in [7:4], units digit in [3:0].
    state_t     r_state;
    logic [7:0] r_sec;
    logic [7:0] r_min;
    logic [7:0] r_hour;
    logic       r_tick;

    state_t     w_state_nxt;
    logic [7:0] w_sec_nxt;
    logic [7:0] w_min_nxt;
    logic [7:0] w_hour_nxt;
    logic       w_tick_nxt;

`ifdef TWELVE_HOUR_EN
    logic       r_pm;
    logic       w_pm_nxt;
`endif

    // 00..59 BCD increment with wrap; shared by seconds and minutes.
    function automatic logic [7:0] f_inc_sixty(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h59)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Hour BCD increment: 00..23 or 12,01..11 depending on the build.
    function automatic logic [7:0] f_inc_hour(input logic [7:0] v);
        logic [7:0] r;
`ifdef TWELVE_HOUR_EN
        if (v == 8'h12)
            r = 8'h01;
`else
        if (v == 8'h23)
            r = 8'h00;
`endif
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Next-state and next-time logic. Within one edge mode_key wins over
    // inc_key, which wins over sec_en; only the winning action applies.
    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_hour_nxt  = r_hour;
        w_tick_nxt  = 1'b0;
`ifdef TWELVE_HOUR_EN
        w_pm_nxt    = r_pm;
`endif
        case (r_state)
            ST_RUN: begin
                if (mode_key) begin
                    // Seconds are zeroed on entry so the edit resumes at :00.
                    w_state_nxt = ST_SET_HOUR;
                    w_sec_nxt   = 8'h00;
                end else if (sec_en) begin
                    w_sec_nxt = f_inc_sixty(r_sec);
                    if (r_sec == 8'h59) begin
                        w_min_nxt = f_inc_sixty(r_min);
                        if (r_min == 8'h59) begin
                            w_hour_nxt = f_inc_hour(r_hour);
                            w_tick_nxt = 1'b1;
`ifdef TWELVE_HOUR_EN
                            if (r_hour == 8'h11)
                                w_pm_nxt = ~r_pm;
`endif
                        end
                    end
                end
            end
            ST_SET_HOUR: begin
                if (mode_key) begin
                    w_state_nxt = ST_SET_MIN;
                end else if (inc_key) begin
                    w_hour_nxt = f_inc_hour(r_hour);
`ifdef TWELVE_HOUR_EN
                    if (r_hour == 8'h11)
                        w_pm_nxt = ~r_pm;
`endif
                end
            end
            ST_SET_MIN: begin
                if (mode_key) begin
                    w_state_nxt = ST_RUN;
                    w_sec_nxt   = 8'h00;
                end else if (inc_key) begin
                    // Minute edit wraps without carrying into the hour.
                    w_min_nxt = f_inc_sixty(r_min);
                end
            end
            default: begin
                // Unreachable encoding: fall back to RUN, keep the time.
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge div_clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_sec   <= 8'h00;
            r_min   <= RST_MIN;
            r_hour  <= RST_HOUR;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sec   <= w_sec_nxt;
            r_min   <= w_min_nxt;
            r_hour  <= w_hour_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

`ifdef TWELVE_HOUR_EN
    always_ff @(posedge div_clk) begin
        if (!rst_n)
            r_pm <= 1'b0;
        else
            r_pm <= w_pm_nxt;
    end
    assign pm = r_pm;
`else
    assign pm = 1'b0;
`endif

    assign secL      = r_sec[3:0];
    assign secH      = r_sec[7:4];
    assign minL      = r_min[3:0];
    assign minH      = r_min[7:4];
    assign hourL     = r_hour[3:0];
    assign hourH     = r_hour[7:4];
    assign mode      = r_state;
    assign hour_tick = r_tick;

endmodule
